// File: rtl/alu_decode_stage.sv
// ---------------------------------------------------------------------------
// alu_decode_stage
//   Decodes a MIPS ALU instruction word into ALU control fields and buffers
//   the result in a two-entry skid buffer (output register + skid register)
//   with a valid/ready handshake on both sides.
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset (highest priority)
//   flush        synchronous discard of all buffered entries
//   in_valid     instruction word present on instr
//   in_ready     stage can accept a word this cycle (from registered state)
//   instr        32-bit MIPS instruction word
//   out_valid    decoded entry present on the outputs
//   out_ready    ALU stage consumes the entry this cycle
//   alu_control  ALU operation code
//   shamt        instr[10:6] for R-type, 0 otherwise
//   rs_idx       instr[25:21]
//   rt_idx       instr[20:16]
//   dst_idx      destination register (rd for R-type, rt for I-type)
//   imm32        sign/zero-extended immediate, 0 for R-type
//   use_imm      ALU rt operand comes from imm32
//   ovf_trap_en  ALU overflow raises an exception (add, sub, addi)
//   illegal      unsupported instruction; still passed through handshake
// ---------------------------------------------------------------------------
module alu_decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  alu_control,
    output logic [4:0]  shamt,
    output logic [4:0]  rs_idx,
    output logic [4:0]  rt_idx,
    output logic [4:0]  dst_idx,
    output logic [31:0] imm32,
    output logic        use_imm,
    output logic        ovf_trap_en,
    output logic        illegal
);

    typedef enum logic [4:0] {
        ALU_SLL  = 5'd0,
        ALU_SRL  = 5'd1,
        ALU_SRA  = 5'd2,
        ALU_SLLV = 5'd3,
        ALU_SRLV = 5'd4,
        ALU_SRAV = 5'd5,
        ALU_ADD  = 5'd6,
        ALU_ADDU = 5'd7,
        ALU_SUB  = 5'd8,
        ALU_SUBU = 5'd9,
        ALU_AND  = 5'd10,
        ALU_OR   = 5'd11,
        ALU_XOR  = 5'd12,
        ALU_NOR  = 5'd13,
        ALU_SLT  = 5'd14,
        ALU_SLTU = 5'd15,
        ALU_LUI  = 5'd16
    } alu_op_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        alu_op_t     alu_control;
        logic [4:0]  shamt;
        logic [4:0]  rs_idx;
        logic [4:0]  rt_idx;
        logic [4:0]  dst_idx;
        logic [31:0] imm32;
        logic        use_imm;
        logic        ovf_trap_en;
        logic        illegal;
    } entry_t;

    logic [5:0] opcode;
    logic [5:0] funct;
    entry_t     dec;
    entry_t     out_q;
    entry_t     skid_q;
    state_t     state_q;
    state_t     state_d;
    logic       accept;
    logic       consume;
    logic       load_out;
    logic       load_skid;
    logic       skid_to_out;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    always_comb begin
        dec        = '0;
        dec.rs_idx = instr[25:21];
        dec.rt_idx = instr[20:16];
        case (opcode)
            6'h00: begin
                dec.shamt   = instr[10:6];
                dec.dst_idx = instr[15:11];
                case (funct)
                    6'h00: dec.alu_control = ALU_SLL;
                    6'h02: dec.alu_control = ALU_SRL;
                    6'h03: dec.alu_control = ALU_SRA;
                    6'h04: dec.alu_control = ALU_SLLV;
                    6'h06: dec.alu_control = ALU_SRLV;
                    6'h07: dec.alu_control = ALU_SRAV;
                    6'h20: begin
                        dec.alu_control = ALU_ADD;
                        dec.ovf_trap_en = 1'b1;
                    end
                    6'h21: dec.alu_control = ALU_ADDU;
                    6'h22: begin
                        dec.alu_control = ALU_SUB;
                        dec.ovf_trap_en = 1'b1;
                    end
                    6'h23: dec.alu_control = ALU_SUBU;
                    6'h24: dec.alu_control = ALU_AND;
                    6'h25: dec.alu_control = ALU_OR;
                    6'h26: dec.alu_control = ALU_XOR;
                    6'h27: dec.alu_control = ALU_NOR;
                    6'h2A: dec.alu_control = ALU_SLT;
                    6'h2B: dec.alu_control = ALU_SLTU;
                    default: begin
                        dec.illegal = 1'b1;
                        dec.shamt   = '0;
                        dec.dst_idx = '0;
                    end
                endcase
            end
            6'h08: begin
                dec.alu_control = ALU_ADD;
                dec.ovf_trap_en = 1'b1;
            end
            6'h09: dec.alu_control = ALU_ADDU;
            6'h0A: dec.alu_control = ALU_SLT;
            6'h0B: dec.alu_control = ALU_SLTU;
            6'h0C: dec.alu_control = ALU_AND;
            6'h0D: dec.alu_control = ALU_OR;
            6'h0E: dec.alu_control = ALU_XOR;
            6'h0F: dec.alu_control = ALU_LUI;
            default: dec.illegal = 1'b1;
        endcase

        // Opcodes 0x08-0x0F are exactly the supported I-type set; bit 2
        // separates the signed group (0x08-0x0B) from the logical group.
        if (opcode[5:3] == 3'b001) begin
            dec.dst_idx = instr[20:16];
            dec.use_imm = 1'b1;
            dec.imm32   = opcode[2] ? {16'h0000, instr[15:0]}
                                    : {{16{instr[15]}}, instr[15:0]};
        end
    end

    // ------------------------------------------------------------------
    // Skid-buffer control
    // ------------------------------------------------------------------
    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != FULL);
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d  = ONE;
                    load_out = 1'b1;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (consume) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (consume) begin
                    state_d     = ONE;
                    skid_to_out = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d     = EMPTY;
            load_out    = 1'b0;
            load_skid   = 1'b0;
            skid_to_out = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out) begin
                out_q <= dec;
            end else if (skid_to_out) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= dec;
            end
        end
    end

    assign alu_control = out_q.alu_control;
    assign shamt       = out_q.shamt;
    assign rs_idx      = out_q.rs_idx;
    assign rt_idx      = out_q.rt_idx;
    assign dst_idx     = out_q.dst_idx;
    assign imm32       = out_q.imm32;
    assign use_imm     = out_q.use_imm;
    assign ovf_trap_en = out_q.ovf_trap_en;
    assign illegal     = out_q.illegal;

endmodule
